wb_stage: RTL

Write-back stage directly upstream of the register file. It accepts completed instructions from execute/memory over a valid/ready handshake and buffers them in a small FIFO. It selects the result source (ALU, load data, or link address for JAL/JALR into R7) and drives the register file write port one cycle later. It also checks the register file's write acknowledge, provides a bypass copy of the in-flight write, counts retired instructions and manages halt drain.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result sources, stage states and the
// buffered entry format.
package wb_pkg;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_LINK = 2'd2,
      SRC_RSVD = 2'd3
   } wb_src_e;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic        wr;
      logic [2:0]  dest;
      wb_src_e     src;
      logic [15:0] alu;
      logic [15:0] mem;
      logic [15:0] pc;
      logic        halt;
   } wb_entry_t;

   localparam logic [2:0] LINK_REG = 3'd7;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries; head is visible on dout
// whenever the FIFO is non-empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   wb_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: buffers completed instructions, selects the result source,
// drives the register file write port and drains cleanly on HALT.
module wb_stage
   import wb_pkg::*;
#(
   parameter int          DEPTH  = 2,
   parameter logic [15:0] PC_INC = 16'd2,
   parameter int          CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_wr,
   input  logic [2:0]       in_dest,
   input  logic [1:0]       in_src,
   input  logic [15:0]      in_alu,
   input  logic [15:0]      in_mem,
   input  logic [15:0]      in_pc,
   input  logic             in_halt,
   output logic             rf_wr,
   output logic [2:0]       rf_dest,
   output logic [15:0]      rf_data,
   input  logic             rf_wr_success,
   output logic             byp_valid,
   output logic [2:0]       byp_dest,
   output logic [15:0]      byp_data,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             wr_err
);

   wb_state_e        state_q, state_d;
   logic             rf_wr_q, rf_wr_d;
   logic [2:0]       rf_dest_q, rf_dest_d;
   logic [15:0]      rf_data_q, rf_data_d;
   logic             ack_exp_q;
   logic             wr_err_q, wr_err_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   wb_entry_t in_entry, head;
   logic      fifo_full, fifo_empty, push, pop;
   logic [2:0]  sel_dest;
   logic [15:0] sel_data;

   assign in_entry = '{wr: in_wr, dest: in_dest, src: wb_src_e'(in_src), alu: in_alu,
                       mem: in_mem, pc: in_pc, halt: in_halt};

   assign in_ready = !fifo_full && (state_q == RUN);
   assign push     = in_valid && in_ready;
   assign pop      = !fifo_empty && (state_q == RUN);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      sel_dest = head.dest;
      sel_data = head.alu;
      unique case (head.src)
         SRC_ALU:  sel_data = head.alu;
         SRC_MEM:  sel_data = head.mem;
         SRC_LINK: begin
            sel_data = head.pc + PC_INC;
            sel_dest = LINK_REG;
         end
         SRC_RSVD: sel_data = head.alu;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      rf_wr_d   = 1'b0;
      rf_dest_d = rf_dest_q;
      rf_data_d = rf_data_q;
      wr_err_d  = wr_err_q;
      retired_d = retired_q;

      if (pop) begin
         if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
         if (head.src == SRC_RSVD) begin
            wr_err_d = 1'b1;
         end else if (head.wr) begin
            rf_wr_d   = 1'b1;
            rf_dest_d = sel_dest;
            rf_data_d = sel_data;
         end
      end

      // Covers both a missing acknowledge and an acknowledge with no write pending.
      if (ack_exp_q != rf_wr_success) wr_err_d = 1'b1;

      case (state_q)
         RUN:     if (pop && head.halt) state_d = DRAIN;
         DRAIN:   if (!ack_exp_q && !rf_wr_q) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         rf_wr_q   <= 1'b0;
         rf_dest_q <= '0;
         rf_data_q <= '0;
         ack_exp_q <= 1'b0;
         wr_err_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         rf_wr_q   <= rf_wr_d;
         rf_dest_q <= rf_dest_d;
         rf_data_q <= rf_data_d;
         ack_exp_q <= rf_wr_q;
         wr_err_q  <= wr_err_d;
         retired_q <= retired_d;
      end
   end

   assign rf_wr     = rf_wr_q;
   assign rf_dest   = rf_dest_q;
   assign rf_data   = rf_data_q;
   assign byp_valid = rf_wr_q;
   assign byp_dest  = rf_dest_q;
   assign byp_data  = rf_data_q;
   assign retired   = retired_q;
   assign halted    = (state_q == HALTED);
   assign wr_err    = wr_err_q;

endmodule
